debounce_multi: RTL and testbench

//   Parametrised multi-channel debouncer for push-button/switch inputs.

---
 rtl/debounce_multi.sv | 139 +++++++++++++
 tb/tb_debounce_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: sync, prescaled sampling, STABLE_COUNT-tick qualification, rise/fall strobes.
// Latency SYNC_STAGES + STABLE_COUNT ticks, no backpressure; define DEBOUNCE_REPEAT_EN for held-key auto-repeat.
module debounce_multi #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int TICK_DIV      = 50000,
  parameter int STABLE_COUNT  = 8,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] outp,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic             sample_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  if (SYNC_STAGES < 2 || TICK_DIV < 1 || STABLE_COUNT < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("debounce_multi: invalid parameter set");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [PW-1:0]                     pre_q, pre_d;
  logic                              tick_q, tick_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  outp_q, outp_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], inp};
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    // Registered so the tick reads 0 during reset even when TICK_DIV is 1.
    tick_d = (pre_d == PRE_LAST);
  end

  always_comb begin
    cnt_d  = cnt_q;
    outp_d = outp_q;
    rise_d = '0;
    fall_d = '0;
    if (tick_q) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (sync_out[c] != outp_q[c]) begin
          if (cnt_q[c] == CNT_LAST) begin
            outp_d[c] = sync_out[c];
            cnt_d[c]  = '0;
            rise_d[c] = sync_out[c];
            fall_d[c] = ~sync_out[c];
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end else begin
          cnt_d[c] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      outp_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      outp_q <= outp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign outp        = outp_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign sample_tick = tick_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  logic [WIDTH-1:0][HW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]         rep_q, rep_d;

  // Once past the first fire point the counter cycles over
  // HOLD_FIRE..HOLD_LAST, so it stays bounded however long the key is held.
  always_comb begin
    hold_d = hold_q;
    rep_d  = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (!outp_d[c] || rise_d[c]) begin
        hold_d[c] = '0;
      end else if (tick_q) begin
        if (hold_q[c] == HOLD_LAST) begin
          hold_d[c] = HOLD_FIRE;
        end else begin
          hold_d[c] = hold_q[c] + 1'b1;
        end
        rep_d[c] = (hold_d[c] == HOLD_FIRE);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (TICK_DIV 1 and 5) against a sample-window model.
module tb_debounce_multi;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic [W-1:0] inp_a, outp_a, rise_a, fall_a, rep_a;
  logic [W-1:0] inp_b, outp_b, rise_b, fall_b, rep_b;
  logic tick_a, tick_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  debounce_multi #(.WIDTH(W), .SYNC_STAGES(SS), .TICK_DIV(1), .STABLE_COUNT(SC),
                   .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clock(clock), .reset_n(reset_n), .inp(inp_a), .outp(outp_a), .rise(rise_a),
    .fall(fall_a), .repeat_pulse(rep_a), .sample_tick(tick_a));

  debounce_multi #(.WIDTH(W), .SYNC_STAGES(SS), .TICK_DIV(5), .STABLE_COUNT(SC),
                   .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clock(clock), .reset_n(reset_n), .inp(inp_b), .outp(outp_b), .rise(rise_b),
    .fall(fall_b), .repeat_pulse(rep_b), .sample_tick(tick_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the level flips once the last SC tick samples all disagree with it.
  logic [W-1:0] m_pipe [2][SS];
  logic [W-1:0] m_win  [2][SC];
  int           m_nwin [2];
  int           m_edges[2];
  logic         m_tick [2];
  logic [W-1:0] m_outp [2];
  logic [W-1:0] m_rise [2];
  logic [W-1:0] m_fall [2];
  logic [W-1:0] m_rep  [2];
  int           m_held [2][W];

  function automatic int td(input int i);
    return (i == 0) ? 1 : 5;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SS; k++) m_pipe[i][k] = '0;
      for (int k = 0; k < SC; k++) m_win[i][k] = '0;
      for (int c = 0; c < W; c++) m_held[i][c] = 0;
      m_nwin[i] = 0; m_edges[i] = 0; m_tick[i] = 1'b0;
      m_outp[i] = '0; m_rise[i] = '0; m_fall[i] = '0; m_rep[i] = '0;
    end
  endtask

  task automatic model_edge(input int i, input logic [W-1:0] in_now);
    logic [W-1:0] s;
    bit all_diff;
    s = m_pipe[i][SS-1];
    m_rise[i] = '0; m_fall[i] = '0; m_rep[i] = '0;
    if (m_tick[i]) begin
      for (int k = SC-1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
      m_win[i][0] = s;
      if (m_nwin[i] < SC) m_nwin[i]++;
      for (int c = 0; c < W; c++) begin
        all_diff = (m_nwin[i] == SC);
        for (int k = 0; k < SC; k++)
          if (m_win[i][k][c] == m_outp[i][c]) all_diff = 1'b0;
        if (all_diff) begin
          m_outp[i][c] = ~m_outp[i][c];
          if (m_outp[i][c]) begin
            m_rise[i][c] = 1'b1;
            m_held[i][c] = 0;
          end else begin
            m_fall[i][c] = 1'b1;
          end
        end else if (m_outp[i][c]) begin
          m_held[i][c]++;
          if (REP_ON && (m_held[i][c] == RD ||
              (m_held[i][c] > RD && (m_held[i][c] - RD) % RP == 0)))
            m_rep[i][c] = 1'b1;
        end
      end
    end
    for (int k = SS-1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
    m_pipe[i][0] = in_now;
    m_edges[i]++;
    m_tick[i] = (m_edges[i] % td(i) == td(i) - 1);
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_edge(0, inp_a);
      model_edge(1, inp_b);
    end
  end

  task automatic cmp_inst(input int i, input string tag, input logic [W-1:0] o,
                          input logic [W-1:0] r, input logic [W-1:0] f,
                          input logic [W-1:0] p, input logic t);
    chk({tag, "_outp"}, 32'(o), 32'(m_outp[i]));
    chk({tag, "_rise"}, 32'(r), 32'(m_rise[i]));
    chk({tag, "_fall"}, 32'(f), 32'(m_fall[i]));
    chk({tag, "_repeat"}, 32'(p), 32'(m_rep[i]));
    chk({tag, "_tick"}, 32'(t), 32'(m_tick[i]));
    chk({tag, "_rise_fall_excl"}, 32'(r & f), 32'd0);
  endtask

  always @(negedge clock) begin
    cmp_inst(0, "a", outp_a, rise_a, fall_a, rep_a, tick_a);
    cmp_inst(1, "b", outp_b, rise_b, fall_b, rep_b, tick_b);
  end

  int n, cnt;
  logic seen;
  logic [31:0] mask, expm;

  initial begin
    inp_a = '0; inp_b = '0; reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_outp", 32'(outp_a), 32'd0);
    chk("rst_rise", 32'(rise_a), 32'd0);
    chk("rst_tick_a", 32'(tick_a), 32'd0);
    chk("rst_tick_b", 32'(tick_b), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Clean step on channel 0
    inp_a = 4'b0001;
    repeat (5) @(negedge clock);
    chk("t1_outp_e5", 32'(outp_a), 32'h0);
    @(negedge clock);
    chk("t1_outp_e6", 32'(outp_a), 32'h1);
    chk("t1_rise_e6", 32'(rise_a), 32'h1);
    chk("t1_fall_e6", 32'(fall_a), 32'h0);
    @(negedge clock);
    chk("t1_rise_e7", 32'(rise_a), 32'h0);

    // Bouncing channel 1
    seen = 1'b0;
    for (int b = 0; b < 20; b++) begin
      inp_a[1] = 1'b1;
      repeat (3) begin @(negedge clock); seen |= rise_a[1] | outp_a[1]; end
      inp_a[1] = 1'b0;
      @(negedge clock); seen |= rise_a[1] | outp_a[1];
    end
    repeat (4) begin @(negedge clock); seen |= rise_a[1] | outp_a[1]; end
    chk("t2_bounce_ignored", 32'(seen), 32'd0);
    inp_a[1] = 1'b1;
    repeat (5) @(negedge clock);
    chk("t2_outp_e5", 32'(outp_a), 32'h1);
    @(negedge clock);
    chk("t2_outp_e6", 32'(outp_a), 32'h3);
    chk("t2_rise_e6", 32'(rise_a), 32'h2);
    inp_a = '0;
    repeat (10) @(negedge clock);
    chk("t2_cleared", 32'(outp_a), 32'h0);

    // Two-channel press and release
    inp_a = 4'b1010;
    repeat (5) @(negedge clock);
    chk("t3_outp_e5", 32'(outp_a), 32'h0);
    @(negedge clock);
    chk("t3_outp_e6", 32'(outp_a), 32'ha);
    chk("t3_rise_e6", 32'(rise_a), 32'ha);
    @(negedge clock);
    chk("t3_rise_e7", 32'(rise_a), 32'h0);
    repeat (13) @(negedge clock);
    inp_a = '0;
    repeat (5) @(negedge clock);
    chk("t3_rel_e5", 32'(outp_a), 32'ha);
    @(negedge clock);
    chk("t3_rel_e6", 32'(outp_a), 32'h0);
    chk("t3_fall_e6", 32'(fall_a), 32'ha);
    @(negedge clock);
    chk("t3_fall_e7", 32'(fall_a), 32'h0);

    // Asynchronous reset mid-qualification
    inp_a = 4'b0101;
    repeat (8) @(negedge clock);
    chk("t4_pre", 32'(outp_a), 32'h5);
    inp_a = 4'b1111;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_async_outp", 32'(outp_a), 32'h0);
    chk("t4_async_tick", 32'(tick_a), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("t4_outp_e5", 32'(outp_a), 32'h0);
    @(negedge clock);
    chk("t4_outp_e6", 32'(outp_a), 32'hf);
    chk("t4_rise_e6", 32'(rise_a), 32'hf);

    // Prescaled instance
    cnt = 0;
    repeat (20) begin @(negedge clock); cnt += int'(tick_b); end
    chk("t5_ticks_per_20", 32'(cnt), 32'd4);
    inp_b[2] = 1'b1;
    n = 0;
    while (outp_b[2] == 1'b0 && n < 40) begin @(negedge clock); n++; end
    chk("t5_latency_in_range", 32'(n >= 18 && n <= 22), 32'd1);
    chk("t5_rise", 32'(rise_b), 32'h4);
    inp_b[2] = 1'b0;
    n = 0;
    while (outp_b[2] == 1'b1 && n < 40) begin @(negedge clock); n++; end
    chk("t5_fall_seen", 32'(outp_b[2]), 32'd0);
    repeat (5) @(negedge clock);
    seen = 1'b0;
    inp_b[2] = 1'b1;
    repeat (12) begin @(negedge clock); seen |= outp_b[2]; end
    inp_b[2] = 1'b0;
    repeat (30) begin @(negedge clock); seen |= outp_b[2] | rise_b[2]; end
    chk("t5_glitch_blocked", 32'(seen), 32'd0);

    // Auto-repeat on channel 3
    inp_a = '0;
    repeat (10) @(negedge clock);
    inp_a[3] = 1'b1;
    n = 0;
    while (rise_a[3] == 1'b0 && n < 20) begin @(negedge clock); n++; end
    chk("t6_rise_seen", 32'(rise_a[3]), 32'd1);
    mask = '0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      if (rep_a[3]) mask[k] = 1'b1;
    end
    expm = REP_ON ? ((32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16)) : 32'd0;
    chk("t6_repeat_positions", mask, expm);
    inp_a[3] = 1'b0;
    n = 0;
    while (fall_a[3] == 1'b0 && n < 20) begin @(negedge clock); n++; end
    chk("t6_fall_seen", 32'(fall_a[3]), 32'd1);
    cnt = 0;
    repeat (20) begin @(negedge clock); cnt += int'(rep_a[3]); end
    chk("t6_no_repeat_after_release", 32'(cnt), 32'd0);

    // Random traffic with one asynchronous reset in the middle
    for (int r = 0; r < 4000; r++) begin
      if ($urandom_range(0, 5) == 0) inp_a ^= 4'($urandom);
      if ($urandom_range(0, 25) == 0) inp_b ^= 4'($urandom);
      if (r == 2000) begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
      end
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
